bp_me_mem_cmd_arbiter: RTL and testbench
========================================

BP_ME_MEM_CMD_ARBITER -- requirements
Module: bp_me_mem_cmd_arbiter

Interface
REQ-001 Parameter bp_params_p, default bp_cfg_gp, selects the processor configuration; msg width = bedrock cce mem msg width derived from it.
REQ-002 Parameter num_req_p, default 2, sets the number of requesters, range 2..4.
REQ-003 Parameter max_outstanding_p, default 8, sets the outstanding-command limit; power of 2.
REQ-004 Port clk_i, input, 1 bit: sole clock.
REQ-005 Port reset_n_i, input, 1 bit: reset, asynchronous, active-low.
REQ-006 Port req_cmd_i, input, num_req_p x msg: requester commands.
REQ-007 Port req_cmd_v_i, input, num_req_p: command valid.
REQ-008 Port req_cmd_ready_o, output, num_req_p: command accepted this cycle (valid-ready).
REQ-009 Port req_resp_o, output, msg: response broadcast to all requesters.
REQ-010 Port req_resp_v_o, output, num_req_p: one-hot response valid.
REQ-011 Port req_resp_yumi_i, input, num_req_p: response consumed.
REQ-012 Port mem_cmd_o, output, msg: arbitrated command.
REQ-013 Port mem_cmd_v_o, output, 1: arbitrated command valid.
REQ-014 Port mem_cmd_ready_i, input, 1: downstream accepts the command.
REQ-015 Port mem_resp_i, input, msg: downstream response.
REQ-016 Port mem_resp_v_i, input, 1: downstream response valid.
REQ-017 Port mem_resp_yumi_o, output, 1: downstream response consumed.
REQ-018 Port credits_o, output, clog2(max_outstanding_p)+1 bits: outstanding-command count.
REQ-019 Port err_o, output, 1: sticky response-without-command error.

Function
REQ-020 Arbitration: round-robin among requesters with req_cmd_v_i high; search starts at the last winner plus one; a single valid requester wins immediately.
REQ-021 Arbitration is enabled only when credits_o < max_outstanding_p.
REQ-022 mem_cmd_v_o = arbitration enabled AND any valid requester; mem_cmd_o = winner's command, muxed combinationally with zero latency.
REQ-023 req_cmd_ready_o[w] = mem_cmd_v_o & mem_cmd_ready_i for winner w only; all other ready bits are 0.
REQ-024 The round-robin pointer advances only on an accepted handshake; a stalled winner keeps the grant, and its command stays stable until accepted.
REQ-025 Each accepted command pushes the winner id into a tag FIFO of depth max_outstanding_p.
REQ-026 Downstream responses arrive in command order.
REQ-027 Response path: req_resp_v_o = one-hot(head tag) when mem_resp_v_i is high and the FIFO is non-empty; req_resp_o = mem_resp_i with zero latency.
REQ-028 mem_resp_yumi_o = req_resp_yumi_i[head tag] & mem_resp_v_i & FIFO non-empty; it pops the tag.
REQ-029 Credit counter: +1 on command accept, -1 on response yumi, unchanged when both occur in one cycle.
REQ-030 Full (credits = max): no grant and all ready bits 0, even with mem_cmd_ready_i high.
REQ-031 Full: a response pop in the same cycle re-enables arbitration on the next cycle, not the same cycle.
REQ-032 Empty: a downstream response is not yumied and req_resp_v_o = 0.
REQ-033 Empty: err_o sets and holds until reset.
REQ-034 Tag FIFO pointers wrap modulo max_outstanding_p without loss.
REQ-035 Command and response traffic proceed concurrently; no structural stall between the two paths.

Reset
REQ-036 While reset_n_i = 0, asynchronously: credits_o = 0, FIFO empty, err_o = 0, pointer = requester 0.
REQ-037 During reset all valid, ready and yumi outputs are 0.
REQ-038 Reset mid-operation discards outstanding tags; late responses after reset are treated as empty-case (REQ-032, REQ-033).
REQ-039 Reset deassertion is synchronized externally; the first grant may occur on the first clk_i edge after deassertion.

Structure
REQ-040 Requester-id width and max_outstanding default are localparams in bp_me_pkg; the message struct comes from the bedrock mem-if macros.
REQ-041 The tag FIFO is one sub-module instance, bsg_fifo_1r1w_small (unhardened).
REQ-042 The tag FIFO is adapted to asynchronous active-low reset by local wrapping; the arbiter logic is inline.

Verification
REQ-043 Both requesters valid continuously, mem_cmd_ready_i = 1, max = 8: grants alternate 0,1,0,1; after 8 accepts, ready drops and credits_o = 8.
REQ-044 Requester 1 issues 3 commands, then requester 0 issues 2; in-order responses: req_resp_v_o sequence = 2,2,2,1,1; credits_o returns to 0.
REQ-045 At credits_o = 8: a response yumi and a pending command in the same cycle give credits_o = 7 next cycle; the grant occurs next cycle; count then returns to 8.
REQ-046 mem_cmd_ready_i held 0 for 5 cycles with requester 1 winning: requester 1's grant is held, no pointer change, no push; accept on release.
REQ-047 mem_resp_v_i asserted with empty FIFO: mem_resp_yumi_o = 0, req_resp_v_o = 0, err_o = 1 held.
REQ-048 reset_n_i pulsed low mid-burst with 4 outstanding: credits_o, err_o and the outputs clear immediately; the next grant goes to requester 0.

Source files
------------

// File: rtl/bp_me_pkg.sv
// Shared memory-engine definitions: requester-id sizing, outstanding-command
// default and the BedRock memory message layout used to size the datapath.
package bp_me_pkg;

  localparam int bp_me_req_id_width_gp      = 2;
  localparam int bp_me_max_outstanding_gp   = 8;

  typedef enum logic [1:0] {
    e_bp_cfg_default = 2'd0,
    e_bp_cfg_wide    = 2'd1
  } bp_cfg_e;

  localparam int bp_cfg_gp = int'(e_bp_cfg_default);

  typedef struct packed {
    logic [15:0] payload;
    logic [2:0]  size;
    logic [39:0] addr;
    logic [3:0]  msg_type;
  } bp_bedrock_mem_header_s;

  function automatic int bp_bedrock_mem_msg_width(input int cfg);
    return $bits(bp_bedrock_mem_header_s) + ((cfg == int'(e_bp_cfg_wide)) ? 128 : 64);
  endfunction

endpackage

// File: rtl/bp_me_mem_cmd_arbiter_fifo.sv
// Small 1-read/1-write FIFO holding requester tags of outstanding commands,
// with asynchronous active-low reset of the pointers (storage is not reset).
module bsg_fifo_1r1w_small #(
  parameter int width_p = 2,
  parameter int els_p   = 8
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;

  // Extra MSB on each pointer distinguishes full from empty on wrap.
  logic [ptr_w:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [width_p-1:0]   mem_q [els_p];
  logic                 full, empty, push;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[ptr_w] != rptr_q[ptr_w]) &&
                   (wptr_q[ptr_w-1:0] == rptr_q[ptr_w-1:0]);
  assign ready_o = ~full;
  assign v_o     = ~empty;
  assign data_o  = mem_q[rptr_q[ptr_w-1:0]];
  assign push    = v_i & ~full;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push)             wptr_d = wptr_q + {{ptr_w{1'b0}}, 1'b1};
    if (yumi_i & ~empty)  rptr_d = rptr_q + {{ptr_w{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q[ptr_w-1:0]] <= data_i;
  end

endmodule

// File: rtl/bp_me_mem_cmd_arbiter.sv
// Round-robin arbiter funnelling requester commands to one memory port and
// routing in-order memory responses back via a tag FIFO, with credit limiting.
module bp_me_mem_cmd_arbiter
  import bp_me_pkg::*;
#(
  parameter int bp_params_p       = bp_cfg_gp,
  parameter int num_req_p         = 2,
  parameter int max_outstanding_p = bp_me_max_outstanding_gp,
  localparam int msg_w            = bp_bedrock_mem_msg_width(bp_params_p),
  localparam int cred_w           = $clog2(max_outstanding_p) + 1
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [num_req_p*msg_w-1:0] req_cmd_i,
  input  logic [num_req_p-1:0]       req_cmd_v_i,
  output logic [num_req_p-1:0]       req_cmd_ready_o,
  output logic [msg_w-1:0]           req_resp_o,
  output logic [num_req_p-1:0]       req_resp_v_o,
  input  logic [num_req_p-1:0]       req_resp_yumi_i,
  output logic [msg_w-1:0]           mem_cmd_o,
  output logic                       mem_cmd_v_o,
  input  logic                       mem_cmd_ready_i,
  input  logic [msg_w-1:0]           mem_resp_i,
  input  logic                       mem_resp_v_i,
  output logic                       mem_resp_yumi_o,
  output logic [cred_w-1:0]          credits_o,
  output logic                       err_o
);

  localparam int id_w = bp_me_req_id_width_gp;
  localparam logic [cred_w-1:0] max_c = cred_w'(max_outstanding_p);

  logic [cred_w-1:0]        credits_q, credits_d;
  logic [id_w-1:0]          rr_q, rr_d, hold_id_q, hold_id_d, win;
  logic                     hold_q, hold_d, err_q, err_d;
  logic                     any_v, arb_en, accept, pop, resp_ok;
  logic                     fifo_ready, fifo_v;
  logic [id_w-1:0]          head;
  logic [num_req_p-1:0]     head_oh;
  logic [2*num_req_p-1:0]   v_rot;

  // Rotate valids so bit 0 is the requester the search starts from.
  always_comb begin : arb_search
    int idx;
    idx   = 0;
    win   = rr_q;
    any_v = 1'b0;
    v_rot = {req_cmd_v_i, req_cmd_v_i} >> rr_q;
    for (int k = num_req_p - 1; k >= 0; k--) begin
      if (v_rot[k]) begin
        idx = int'(rr_q) + k;
        if (idx >= num_req_p) idx = idx - num_req_p;
        win   = id_w'(idx);
        any_v = 1'b1;
      end
    end
    for (int i = 0; i < num_req_p; i++) begin
      if (hold_q && (hold_id_q == id_w'(i)) && req_cmd_v_i[i]) win = id_w'(i);
    end
  end

  // Gating with reset_n_i keeps every handshake output quiet during reset.
  assign arb_en      = reset_n_i & fifo_ready & (credits_q < max_c);
  assign mem_cmd_v_o = arb_en & any_v;
  assign accept      = mem_cmd_v_o & mem_cmd_ready_i;

  always_comb begin
    mem_cmd_o       = '0;
    req_cmd_ready_o = '0;
    for (int i = 0; i < num_req_p; i++) begin
      if (win == id_w'(i)) begin
        mem_cmd_o          = req_cmd_i[i*msg_w +: msg_w];
        req_cmd_ready_o[i] = accept;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < num_req_p; i++) head_oh[i] = (head == id_w'(i));
  end

  assign resp_ok         = mem_resp_v_i & fifo_v;
  assign req_resp_v_o    = resp_ok ? head_oh : '0;
  assign req_resp_o      = mem_resp_i;
  assign pop             = resp_ok & (|(head_oh & req_resp_yumi_i));
  assign mem_resp_yumi_o = pop;
  assign credits_o       = credits_q;
  assign err_o           = err_q;

  always_comb begin
    credits_d = credits_q;
    rr_d      = rr_q;
    hold_d    = hold_q;
    hold_id_d = hold_id_q;
    err_d     = err_q | (mem_resp_v_i & ~fifo_v);
    case ({accept, pop})
      2'b10:   credits_d = credits_q + cred_w'(1);
      2'b01:   credits_d = credits_q - cred_w'(1);
      default: credits_d = credits_q;
    endcase
    if (accept) begin
      rr_d   = (int'(win) == num_req_p - 1) ? '0 : win + id_w'(1);
      hold_d = 1'b0;
    end else if (mem_cmd_v_o) begin
      hold_d    = 1'b1;
      hold_id_d = win;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      credits_q <= '0;
      rr_q      <= '0;
      hold_q    <= 1'b0;
      hold_id_q <= '0;
      err_q     <= 1'b0;
    end else begin
      credits_q <= credits_d;
      rr_q      <= rr_d;
      hold_q    <= hold_d;
      hold_id_q <= hold_id_d;
      err_q     <= err_d;
    end
  end

  bsg_fifo_1r1w_small #(
    .width_p (id_w),
    .els_p   (max_outstanding_p)
  ) tag_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (accept),
    .ready_o   (fifo_ready),
    .data_i    (win),
    .v_o       (fifo_v),
    .data_o    (head),
    .yumi_i    (pop)
  );

endmodule

// File: tb/tb_bp_me_mem_cmd_arbiter.sv
// Directed bench for the memory command arbiter: arbitration order, credit
// limits, response routing, stall hold, empty-response error and reset.
module tb_bp_me_mem_cmd_arbiter;
  import bp_me_pkg::*;

  localparam int MW = bp_bedrock_mem_msg_width(bp_cfg_gp);
  localparam int NR = 2;
  localparam int CW = 4;

  logic              clk_i = 1'b0;
  logic              reset_n_i;
  logic [NR*MW-1:0]  req_cmd_i;
  logic [NR-1:0]     req_cmd_v_i;
  logic [NR-1:0]     req_cmd_ready_o;
  logic [MW-1:0]     req_resp_o;
  logic [NR-1:0]     req_resp_v_o;
  logic [NR-1:0]     req_resp_yumi_i;
  logic [MW-1:0]     mem_cmd_o;
  logic              mem_cmd_v_o;
  logic              mem_cmd_ready_i;
  logic [MW-1:0]     mem_resp_i;
  logic              mem_resp_v_i;
  logic              mem_resp_yumi_o;
  logic [CW-1:0]     credits_o;
  logic              err_o;

  logic [MW-1:0] cmd0, cmd1, rsp;
  int checks = 0;
  int failures = 0;

  bp_me_mem_cmd_arbiter #(.num_req_p(NR), .max_outstanding_p(8)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .req_cmd_i(req_cmd_i), .req_cmd_v_i(req_cmd_v_i), .req_cmd_ready_o(req_cmd_ready_o),
    .req_resp_o(req_resp_o), .req_resp_v_o(req_resp_v_o), .req_resp_yumi_i(req_resp_yumi_i),
    .mem_cmd_o(mem_cmd_o), .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_ready_i(mem_cmd_ready_i),
    .mem_resp_i(mem_resp_i), .mem_resp_v_i(mem_resp_v_i), .mem_resp_yumi_o(mem_resp_yumi_o),
    .credits_o(credits_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    cmd0 = MW'(128'h0123_4567_89ab_cdef_0011_2233_4455_6677);
    cmd1 = MW'(128'h7edc_ba98_7654_3210_ffee_ddcc_bbaa_9988);
    rsp  = MW'(128'h5a5a_a5a5_1234_4321_dead_beef_cafe_f00d);
    req_cmd_i = {cmd1, cmd0};
    reset_n_i = 1'b0;
    req_cmd_v_i = 2'b11;
    mem_cmd_ready_i = 1'b1;
    mem_resp_i = rsp;
    mem_resp_v_i = 1'b1;
    req_resp_yumi_i = 2'b11;

    // Reset: everything quiet even with stimulus active.
    #3;
    chk("rst_cmd_v", mem_cmd_v_o, 0);
    chk("rst_ready", req_cmd_ready_o, 0);
    chk("rst_resp_v", req_resp_v_o, 0);
    chk("rst_yumi", mem_resp_yumi_o, 0);
    chk("rst_credits", credits_o, 0);
    chk("rst_err", err_o, 0);
    req_cmd_v_i = 2'b00;
    mem_resp_v_i = 1'b0;
    step();
    reset_n_i = 1'b1;

    // Alternating grants until credits are exhausted.
    req_cmd_v_i = 2'b11;
    for (int k = 0; k < 8; k++) begin
      settle();
      chk("rr_ready", req_cmd_ready_o, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk("rr_cmd", mem_cmd_o, (k % 2 == 0) ? cmd0 : cmd1);
      chk("rr_credits", credits_o, k);
      step();
    end
    settle();
    chk("full_ready", req_cmd_ready_o, 0);
    chk("full_cmd_v", mem_cmd_v_o, 0);
    chk("full_credits", credits_o, 8);

    // Pop while full: no same-cycle grant, grant on the following cycle.
    mem_resp_v_i = 1'b1;
    settle();
    chk("fullpop_cmd_v", mem_cmd_v_o, 0);
    chk("fullpop_resp_v", req_resp_v_o, 2'b01);
    chk("fullpop_yumi", mem_resp_yumi_o, 1);
    chk("fullpop_resp", req_resp_o, rsp);
    step();
    mem_resp_v_i = 1'b0;
    settle();
    chk("refill_credits", credits_o, 7);
    chk("refill_ready", req_cmd_ready_o, 2'b01);
    step();
    settle();
    chk("refull_credits", credits_o, 8);

    // Drain eight in-order responses; tag order is 1,0,1,0,...
    req_cmd_v_i = 2'b00;
    mem_resp_v_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      settle();
      chk("drain_resp_v", req_resp_v_o, (k % 2 == 0) ? 2'b10 : 2'b01);
      chk("drain_credits", credits_o, 8 - k);
      step();
    end
    mem_resp_v_i = 1'b0;
    settle();
    chk("drain_done", credits_o, 0);

    // Requester 1 issues three, then requester 0 issues two.
    req_cmd_v_i = 2'b10;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("r1_ready", req_cmd_ready_o, 2'b10);
      step();
    end
    req_cmd_v_i = 2'b01;
    for (int k = 0; k < 2; k++) begin
      settle();
      chk("r0_ready", req_cmd_ready_o, 2'b01);
      step();
    end
    req_cmd_v_i = 2'b00;
    mem_resp_v_i = 1'b1;
    req_resp_yumi_i = 2'b01;
    settle();
    chk("wrong_yumi", mem_resp_yumi_o, 0);
    step();
    settle();
    chk("wrong_yumi_cred", credits_o, 5);
    req_resp_yumi_i = 2'b11;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("seq_resp_v", req_resp_v_o, (k < 3) ? 2'b10 : 2'b01);
      chk("seq_credits", credits_o, 5 - k);
      step();
    end
    mem_resp_v_i = 1'b0;
    settle();
    chk("seq_done", credits_o, 0);

    // Downstream stall with requester 1 winning.
    req_cmd_v_i = 2'b11;
    mem_cmd_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("stall_cmd_v", mem_cmd_v_o, 1);
      chk("stall_cmd", mem_cmd_o, cmd1);
      chk("stall_ready", req_cmd_ready_o, 0);
      chk("stall_credits", credits_o, 0);
      step();
    end
    mem_cmd_ready_i = 1'b1;
    settle();
    chk("release_ready", req_cmd_ready_o, 2'b10);
    step();

    // Concurrent accept and pop leave the credit count unchanged.
    req_cmd_v_i = 2'b01;
    mem_resp_v_i = 1'b1;
    settle();
    chk("conc_ready", req_cmd_ready_o, 2'b01);
    chk("conc_resp_v", req_resp_v_o, 2'b10);
    chk("conc_credits0", credits_o, 1);
    step();
    req_cmd_v_i = 2'b00;
    settle();
    chk("conc_credits1", credits_o, 1);
    chk("conc_resp_v2", req_resp_v_o, 2'b01);
    step();
    mem_resp_v_i = 1'b0;
    settle();
    chk("conc_done", credits_o, 0);

    // Response with nothing outstanding.
    mem_resp_v_i = 1'b1;
    settle();
    chk("empty_yumi", mem_resp_yumi_o, 0);
    chk("empty_resp_v", req_resp_v_o, 0);
    step();
    mem_resp_v_i = 1'b0;
    settle();
    chk("err_set", err_o, 1);
    step();
    settle();
    chk("err_held", err_o, 1);

    // Reset mid-burst with four outstanding.
    req_cmd_v_i = 2'b11;
    for (int k = 0; k < 4; k++) step();
    settle();
    chk("burst_credits", credits_o, 4);
    reset_n_i = 1'b0;
    settle();
    chk("midrst_credits", credits_o, 0);
    chk("midrst_err", err_o, 0);
    chk("midrst_cmd_v", mem_cmd_v_o, 0);
    chk("midrst_ready", req_cmd_ready_o, 0);
    step();
    reset_n_i = 1'b1;
    req_cmd_v_i = 2'b00;
    mem_resp_v_i = 1'b1;
    settle();
    chk("late_resp_v", req_resp_v_o, 0);
    chk("late_yumi", mem_resp_yumi_o, 0);
    step();
    mem_resp_v_i = 1'b0;
    req_cmd_v_i = 2'b11;
    settle();
    chk("late_err", err_o, 1);
    chk("post_rst_ready", req_cmd_ready_o, 2'b01);
    step();
    settle();
    chk("post_rst_credits", credits_o, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
